// File: rtl/picorv32_rvfi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : picorv32_rvfi_pkg
// Description : Shared error codes and the write-mask legality function for
//               the PicoRV32 RVFI consistency monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package picorv32_rvfi_pkg;

    localparam int XLEN = 32;

    // Error codes, listed in priority order (lowest non-zero code wins)
    localparam logic [3:0] ERR_NONE  = 4'd0;
    localparam logic [3:0] ERR_ORDER = 4'd1;
    localparam logic [3:0] ERR_PC    = 4'd2;
    localparam logic [3:0] ERR_RS1   = 4'd3;
    localparam logic [3:0] ERR_RS2   = 4'd4;
    localparam logic [3:0] ERR_RD0   = 4'd5;
    localparam logic [3:0] ERR_MEM   = 4'd6;
    localparam logic [3:0] ERR_HALT  = 4'd7;

    // A store may touch one byte, one aligned halfword or the full word;
    // no store at all is also legal.
    function automatic logic wmask_legal(input logic [3:0] wmask);
        case (wmask)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: wmask_legal = 1'b1;
            default:                   wmask_legal = 1'b0;
        endcase
    endfunction

endpackage : picorv32_rvfi_pkg
`default_nettype wire

// File: rtl/picorv32_rvfi_shadow_regs.sv
`default_nettype none
// ============================================================================
// Module      : picorv32_rvfi_shadow_regs
// Description : Shadow copy of the architectural register file as observed
//               through RVFI. Two combinational read ports, one synchronous
//               write port. Each entry carries a valid bit because the core's
//               initial register contents are unknown. x0 always reads as
//               invalid with zero data.
// Revision    : 1.0 - initial release
// ============================================================================
module picorv32_rvfi_shadow_regs
    import picorv32_rvfi_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    output logic [XLEN-1:0] rdata1,
    output logic            rvalid1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata2,
    output logic            rvalid2
);

    // Entry 0 is never written, so its valid bit stays clear forever.
    logic [XLEN-1:0] data [32];
    logic [31:0]     valid_bits;

    // Valid bits: cleared on reset, set on the first write to a register
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_bits <= '0;
        end else if (we && (waddr != 5'd0)) begin
            valid_bits[waddr] <= 1'b1;
        end
    end

    // Data storage needs no reset; entries are ignored until marked valid
    always_ff @(posedge clock) begin
        if (!reset && we && (waddr != 5'd0)) begin
            data[waddr] <= wdata;
        end
    end

    // Combinational read ports with x0 forced to invalid / zero
    always_comb begin
        rvalid1 = 1'b0;
        rdata1  = '0;
        rvalid2 = 1'b0;
        rdata2  = '0;
        if (raddr1 != 5'd0) begin
            rvalid1 = valid_bits[raddr1];
            rdata1  = data[raddr1];
        end
        if (raddr2 != 5'd0) begin
            rvalid2 = valid_bits[raddr2];
            rdata2  = data[raddr2];
        end
    end

endmodule : picorv32_rvfi_shadow_regs
`default_nettype wire

// File: rtl/picorv32_rvfi_monitor.sv
`default_nettype none
// ============================================================================
// Module      : picorv32_rvfi_monitor
// Description : Passive RVFI consistency checker for picorv32_axi (NRET=1).
//               Checks retirement order, PC continuity, register coherence,
//               x0 rules, memory-mask sanity and halt finality. Reports the
//               first violation through a sticky error flag and code.
// Revision    : 1.0 - initial release
// ============================================================================
module picorv32_rvfi_monitor
    import picorv32_rvfi_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        rvfi_valid,
    input  logic [63:0] rvfi_order,
    input  logic [31:0] rvfi_insn,
    input  logic        rvfi_trap,
    input  logic        rvfi_halt,
    input  logic        rvfi_intr,
    input  logic [4:0]  rvfi_rs1_addr,
    input  logic [4:0]  rvfi_rs2_addr,
    input  logic [4:0]  rvfi_rd_addr,
    input  logic [31:0] rvfi_rs1_rdata,
    input  logic [31:0] rvfi_rs2_rdata,
    input  logic [31:0] rvfi_rd_wdata,
    input  logic [31:0] rvfi_pc_rdata,
    input  logic [31:0] rvfi_pc_wdata,
    input  logic [31:0] rvfi_mem_addr,
    input  logic [3:0]  rvfi_mem_rmask,
    input  logic [3:0]  rvfi_mem_wmask,
    input  logic [31:0] rvfi_mem_rdata,
    input  logic [31:0] rvfi_mem_wdata,
    output logic        error,
    output logic [3:0]  errcode
);

    logic [63:0] exp_order;
    logic [31:0] last_pc;
    logic        pc_known;
    logic        halted;

    logic [31:0] sh_rs1_data;
    logic [31:0] sh_rs2_data;
    logic        sh_rs1_valid;
    logic        sh_rs2_valid;
    logic        shadow_we;
    logic [3:0]  first_code;

    // Fields carried on RVFI that no rule inspects
    logic unused_inputs;
    assign unused_inputs = ^{rvfi_insn, rvfi_mem_rdata, rvfi_mem_wdata,
                             rvfi_mem_addr[31:2]};

    // Trapped instructions do not commit their destination register
    assign shadow_we = rvfi_valid && !rvfi_trap && (rvfi_rd_addr != 5'd0);

    picorv32_rvfi_shadow_regs u_shadow (
        .clock   (clock),
        .reset   (reset),
        .we      (shadow_we),
        .waddr   (rvfi_rd_addr),
        .wdata   (rvfi_rd_wdata),
        .raddr1  (rvfi_rs1_addr),
        .rdata1  (sh_rs1_data),
        .rvalid1 (sh_rs1_valid),
        .raddr2  (rvfi_rs2_addr),
        .rdata2  (sh_rs2_data),
        .rvalid2 (sh_rs2_valid)
    );

    // Evaluate all rules against pre-update state; lowest code wins
    always_comb begin
        first_code = ERR_NONE;
        if (rvfi_order != exp_order) begin
            first_code = ERR_ORDER;
        end else if (pc_known && !rvfi_intr && (rvfi_pc_rdata != last_pc)) begin
            first_code = ERR_PC;
        end else if (((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != 32'd0)) ||
                     (sh_rs1_valid && (rvfi_rs1_rdata != sh_rs1_data))) begin
            first_code = ERR_RS1;
        end else if (((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != 32'd0)) ||
                     (sh_rs2_valid && (rvfi_rs2_rdata != sh_rs2_data))) begin
            first_code = ERR_RS2;
        end else if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0)) begin
            first_code = ERR_RD0;
        end else if ((((rvfi_mem_rmask | rvfi_mem_wmask) != 4'd0) &&
                      (rvfi_mem_addr[1:0] != 2'd0)) ||
                     !wmask_legal(rvfi_mem_wmask)) begin
            first_code = ERR_MEM;
        end else if (halted) begin
            first_code = ERR_HALT;
        end
    end

    // Tracking state advances on every retirement; error latches only once
    always_ff @(posedge clock) begin
        if (reset) begin
            exp_order <= 64'd0;
            last_pc   <= 32'd0;
            pc_known  <= 1'b0;
            halted    <= 1'b0;
            error     <= 1'b0;
            errcode   <= ERR_NONE;
        end else if (rvfi_valid) begin
            exp_order <= rvfi_order + 64'd1;
            last_pc   <= rvfi_pc_wdata;
            pc_known  <= 1'b1;
            halted    <= halted | rvfi_halt;
            if (!error && (first_code != ERR_NONE)) begin
                error   <= 1'b1;
                errcode <= first_code;
            end
        end
    end

`ifndef SYNTHESIS
    // Simulation message for the first violation only
    always @(posedge clock) begin
        if (!reset && rvfi_valid && !error && (first_code != ERR_NONE)) begin
            $display("RVFI ERROR %0d order=%0d pc=%08x",
                     first_code, rvfi_order, rvfi_pc_rdata);
        end
    end
`endif

endmodule : picorv32_rvfi_monitor
`default_nettype wire

// File: tb/tb_picorv32_rvfi_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_picorv32_rvfi_monitor
// Description : Directed self-checking bench for picorv32_rvfi_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_picorv32_rvfi_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap, rvfi_halt, rvfi_intr;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata;
    logic [31:0] rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic [31:0] rvfi_mem_rdata, rvfi_mem_wdata;
    logic        error;
    logic [3:0]  errcode;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    picorv32_rvfi_monitor dut (
        .clock          (clock),
        .reset          (reset),
        .rvfi_valid     (rvfi_valid),
        .rvfi_order     (rvfi_order),
        .rvfi_insn      (rvfi_insn),
        .rvfi_trap      (rvfi_trap),
        .rvfi_halt      (rvfi_halt),
        .rvfi_intr      (rvfi_intr),
        .rvfi_rs1_addr  (rvfi_rs1_addr),
        .rvfi_rs2_addr  (rvfi_rs2_addr),
        .rvfi_rd_addr   (rvfi_rd_addr),
        .rvfi_rs1_rdata (rvfi_rs1_rdata),
        .rvfi_rs2_rdata (rvfi_rs2_rdata),
        .rvfi_rd_wdata  (rvfi_rd_wdata),
        .rvfi_pc_rdata  (rvfi_pc_rdata),
        .rvfi_pc_wdata  (rvfi_pc_wdata),
        .rvfi_mem_addr  (rvfi_mem_addr),
        .rvfi_mem_rmask (rvfi_mem_rmask),
        .rvfi_mem_wmask (rvfi_mem_wmask),
        .rvfi_mem_rdata (rvfi_mem_rdata),
        .rvfi_mem_wdata (rvfi_mem_wdata),
        .error          (error),
        .errcode        (errcode)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Benign retirement: no register or memory traffic
    task automatic clear_fields();
        rvfi_valid     = 1'b0;
        rvfi_order     = '0;
        rvfi_insn      = 32'h0000_0013;
        rvfi_trap      = 1'b0;
        rvfi_halt      = 1'b0;
        rvfi_intr      = 1'b0;
        rvfi_rs1_addr  = '0;
        rvfi_rs2_addr  = '0;
        rvfi_rd_addr   = '0;
        rvfi_rs1_rdata = '0;
        rvfi_rs2_rdata = '0;
        rvfi_rd_wdata  = '0;
        rvfi_pc_rdata  = '0;
        rvfi_pc_wdata  = '0;
        rvfi_mem_addr  = '0;
        rvfi_mem_rmask = '0;
        rvfi_mem_wmask = '0;
        rvfi_mem_rdata = '0;
        rvfi_mem_wdata = '0;
    endtask

    // Called at a falling edge; retires one instruction on the next rising edge
    task automatic ret(input logic [63:0] o, input logic [31:0] pr, input logic [31:0] pw);
        rvfi_order    = o;
        rvfi_pc_rdata = pr;
        rvfi_pc_wdata = pw;
        rvfi_valid    = 1'b1;
        @(negedge clock);
        clear_fields();
    endtask

    task automatic do_reset();
        clear_fields();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_fields();
        @(negedge clock);
        do_reset();
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_code", {28'd0, errcode}, 32'd0);

        // Clean write then read-back of x5
        rvfi_rd_addr = 5'd5; rvfi_rd_wdata = 32'h1234;
        ret(0, 32'h0, 32'h4);
        rvfi_rs1_addr = 5'd5; rvfi_rs1_rdata = 32'h1234;
        ret(1, 32'h4, 32'h8);
        check("raw_ok_error", {31'd0, error}, 32'd0);
        check("raw_ok_code", {28'd0, errcode}, 32'd0);

        // Order gap 0,1,3 then a PC fault that must not override
        do_reset();
        ret(0, 32'h0, 32'h4);
        ret(1, 32'h4, 32'h8);
        check("order_pre", {28'd0, errcode}, 32'd0);
        ret(3, 32'h8, 32'hC);
        check("order_error", {31'd0, error}, 32'd1);
        check("order_code", {28'd0, errcode}, 32'd1);
        ret(4, 32'h100, 32'h104);
        check("order_sticky", {28'd0, errcode}, 32'd1);

        // PC discontinuity without and with interrupt entry
        do_reset();
        ret(0, 32'h0, 32'h10);
        ret(1, 32'h14, 32'h18);
        check("pc_code", {28'd0, errcode}, 32'd2);
        do_reset();
        ret(0, 32'h0, 32'h10);
        rvfi_intr = 1'b1;
        ret(1, 32'h14, 32'h18);
        check("pc_intr_ok", {28'd0, errcode}, 32'd0);

        // Stale rs2 value and nonzero x0 read
        do_reset();
        rvfi_rd_addr = 5'd7; rvfi_rd_wdata = 32'hAA;
        ret(0, 32'h0, 32'h4);
        rvfi_rs2_addr = 5'd7; rvfi_rs2_rdata = 32'hAB;
        ret(1, 32'h4, 32'h8);
        check("rs2_code", {28'd0, errcode}, 32'd4);
        do_reset();
        rvfi_rs1_addr = 5'd0; rvfi_rs1_rdata = 32'd1;
        ret(0, 32'h0, 32'h4);
        check("rs1_x0_code", {28'd0, errcode}, 32'd3);

        // Memory mask sanity and x0 write
        do_reset();
        rvfi_mem_wmask = 4'b0110;
        ret(0, 32'h0, 32'h4);
        check("mem_wmask_code", {28'd0, errcode}, 32'd6);
        do_reset();
        rvfi_mem_addr = 32'h1002; rvfi_mem_rmask = 4'b1111;
        ret(0, 32'h0, 32'h4);
        check("mem_align_code", {28'd0, errcode}, 32'd6);
        do_reset();
        rvfi_rd_addr = 5'd0; rvfi_rd_wdata = 32'd5;
        ret(0, 32'h0, 32'h4);
        check("rd0_code", {28'd0, errcode}, 32'd5);

        // Halt finality, then reset clears everything including halted
        do_reset();
        rvfi_halt = 1'b1;
        ret(0, 32'h0, 32'h4);
        check("halt_first_ok", {28'd0, errcode}, 32'd0);
        ret(1, 32'h4, 32'h8);
        check("halt_code", {28'd0, errcode}, 32'd7);
        do_reset();
        ret(0, 32'h0, 32'h4);
        check("post_reset_error", {31'd0, error}, 32'd0);
        check("post_reset_code", {28'd0, errcode}, 32'd0);

        // Same-instruction read/write of x5 checks the old value, then new
        rvfi_rd_addr = 5'd5; rvfi_rd_wdata = 32'h1;
        ret(1, 32'h4, 32'h8);
        rvfi_rs1_addr = 5'd5; rvfi_rs1_rdata = 32'h1;
        rvfi_rd_addr  = 5'd5; rvfi_rd_wdata  = 32'h2;
        ret(2, 32'h8, 32'hC);
        rvfi_rs1_addr = 5'd5; rvfi_rs1_rdata = 32'h2;
        ret(3, 32'hC, 32'h10);
        check("rw_same_code", {28'd0, errcode}, 32'd0);

        // Trapped write is not committed; a different read value is fine
        rvfi_trap = 1'b1; rvfi_rd_addr = 5'd9; rvfi_rd_wdata = 32'h55;
        ret(4, 32'h10, 32'h14);
        rvfi_rs1_addr = 5'd9; rvfi_rs1_rdata = 32'h66;
        ret(5, 32'h14, 32'h18);
        check("trap_nowrite_code", {28'd0, errcode}, 32'd0);

        // ORDER outranks a same-cycle PC fault
        ret(7, 32'h40, 32'h44);
        check("prio_code", {28'd0, errcode}, 32'd1);

        // First retirement after reset must carry order 0
        do_reset();
        ret(1, 32'h0, 32'h4);
        check("first_order_code", {28'd0, errcode}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_picorv32_rvfi_monitor
`default_nettype wire
